// File: rtl/rcc_lse_pkg.sv
// Shared types and default limits for the LSE oscillator controller.
//   lse_state_e : controller state encoding
//   DEF_*       : default parameter values for rcc_lse_ctrl
package rcc_lse_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    STARTUP = 2'd1,
    READY   = 2'd2,
    FAIL    = 2'd3
  } lse_state_e;

  localparam int unsigned DEF_STARTUP_EDGES = 4096;
  localparam int unsigned DEF_BYP_EDGES     = 8;
  localparam int unsigned DEF_CSS_TIMEOUT   = 64;
  localparam int unsigned DEF_CNT_W         = 13;
  localparam int unsigned DEF_WDT_W         = 7;

endpackage

// File: rtl/rcc_lse_edge_det.sv
// LSE edge detector: 2-flop synchronizer, optional glitch filter, rising-edge pulse.
// Optional feature macro: RCC_LSE_GLITCH_FILTER_EN (1-cycle glitch rejection).
// Ports:
//   clk        : monitoring clock
//   rst_n      : synchronous active-low reset
//   lse_clk_in : raw LSE clock, asynchronous to clk
//   edge_c     : one-cycle pulse per synchronized LSE rising edge (combinational)
module rcc_lse_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic lse_clk_in,
  output logic edge_c
);

  logic lse_m;
  logic lse_s;
  logic lse_s_d;

  // Synchronizer plus one delayed copy of the synchronized level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lse_m   <= 1'b0;
      lse_s   <= 1'b0;
      lse_s_d <= 1'b0;
    end else begin
      lse_m   <= lse_clk_in;
      lse_s   <= lse_m;
      lse_s_d <= lse_s;
    end
  end

`ifdef RCC_LSE_GLITCH_FILTER_EN
  logic filt;

  // Filtered level only follows two consecutive agreeing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt <= 1'b0;
    end else if (lse_s == lse_s_d) begin
      filt <= lse_s;
    end
  end

  // Edge fires in the cycle the filtered level is about to rise
  assign edge_c = lse_s & lse_s_d & ~filt;
`else
  assign edge_c = lse_s & ~lse_s_d;
`endif

endmodule

// File: rtl/rcc_lse_ctrl.sv
// LSE oscillator controller: startup edge counting and clock security watchdog.
// Optional feature macro: RCC_LSE_GLITCH_FILTER_EN (passed to rcc_lse_edge_det).
// Ports:
//   clk, rst_n          : monitoring clock (>4x LSE), synchronous active-low reset
//   lse_clk_in          : raw LSE clock
//   lseon, lsebyp       : enable, external-clock bypass
//   lsedrv[1:0]         : crystal drive strength
//   lsecsson            : CSS enable
//   lserdy, lsecss_fail : status back to the register block
//   lse_osc_en, lse_osc_byp, lse_osc_drv[1:0] : analog oscillator controls
module rcc_lse_ctrl
  import rcc_lse_pkg::*;
#(
  parameter int unsigned STARTUP_EDGES = DEF_STARTUP_EDGES,
  parameter int unsigned BYP_EDGES     = DEF_BYP_EDGES,
  parameter int unsigned CSS_TIMEOUT   = DEF_CSS_TIMEOUT,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned WDT_W         = DEF_WDT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lse_clk_in,
  input  logic       lseon,
  input  logic       lsebyp,
  input  logic [1:0] lsedrv,
  input  logic       lsecsson,
  output logic       lserdy,
  output logic       lsecss_fail,
  output logic       lse_osc_en,
  output logic       lse_osc_byp,
  output logic [1:0] lse_osc_drv
);

  localparam logic [CNT_W-1:0] STARTUP_LIM = CNT_W'(STARTUP_EDGES);
  localparam logic [CNT_W-1:0] BYP_LIM     = CNT_W'(BYP_EDGES);
  localparam logic [WDT_W-1:0] WDT_MAX     = WDT_W'(CSS_TIMEOUT);
  localparam logic [WDT_W-1:0] WDT_TRIP    = WDT_W'(CSS_TIMEOUT - 1);

  lse_state_e       state, state_d;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_d;
  logic [WDT_W-1:0] wdt_cnt, wdt_cnt_d;
  logic             byp_l, byp_l_d;
  logic             e;
  logic             lserdy_d, fail_d, osc_en_d, osc_byp_d;
  logic [CNT_W-1:0] lim;

  rcc_lse_edge_det u_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .lse_clk_in (lse_clk_in),
    .edge_c     (e)
  );

  assign lim = byp_l ? BYP_LIM : STARTUP_LIM;

  // State register, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= OFF;
      edge_cnt    <= '0;
      wdt_cnt     <= '0;
      byp_l       <= 1'b0;
      lserdy      <= 1'b0;
      lsecss_fail <= 1'b0;
      lse_osc_en  <= 1'b0;
      lse_osc_byp <= 1'b0;
      lse_osc_drv <= 2'b00;
    end else begin
      state       <= state_d;
      edge_cnt    <= edge_cnt_d;
      wdt_cnt     <= wdt_cnt_d;
      byp_l       <= byp_l_d;
      lserdy      <= lserdy_d;
      lsecss_fail <= fail_d;
      lse_osc_en  <= osc_en_d;
      lse_osc_byp <= osc_byp_d;
      lse_osc_drv <= lsedrv;
    end
  end

  // Next state, counters, and outputs derived from the next state
  always_comb begin
    state_d    = state;
    edge_cnt_d = edge_cnt;
    wdt_cnt_d  = wdt_cnt;
    byp_l_d    = byp_l;

    case (state)
      OFF: begin
        if (lseon) begin
          state_d    = STARTUP;
          byp_l_d    = lsebyp;
          edge_cnt_d = '0;
          wdt_cnt_d  = '0;
        end
      end
      STARTUP: begin
        wdt_cnt_d = '0;
        if (e && (edge_cnt != lim)) begin
          edge_cnt_d = edge_cnt + CNT_W'(1);
        end
        if (edge_cnt_d == lim) begin
          state_d = READY;
        end
      end
      READY: begin
        if (e || !lsecsson) begin
          wdt_cnt_d = '0;
        end else if (wdt_cnt != WDT_MAX) begin
          wdt_cnt_d = wdt_cnt + WDT_W'(1);
        end
        // A same-cycle edge keeps the watchdog alive
        if (lsecsson && !e && (wdt_cnt == WDT_TRIP)) begin
          state_d = FAIL;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = OFF;
      end
    endcase

    // Disable overrides any same-cycle ready or timeout decision
    if ((state != OFF) && !lseon) begin
      state_d    = OFF;
      edge_cnt_d = '0;
      wdt_cnt_d  = '0;
    end

    lserdy_d  = (state_d == READY);
    fail_d    = (state_d == FAIL);
    osc_en_d  = (state_d != OFF) & ~byp_l_d;
    osc_byp_d = (state_d != OFF) & byp_l_d;
  end

endmodule

// File: tb/tb_rcc_lse_ctrl.sv
// Self-checking bench for rcc_lse_ctrl: directed vector table plus sequences
// for startup, CSS timing, reset/disable and glitch handling.
module tb_rcc_lse_ctrl;

`ifdef RCC_LSE_GLITCH_FILTER_EN
  localparam int LAT   = 4;  // lse drive -> output update, in ticks
  localparam int NREAL = 4;  // real bypass periods needed after two glitches
`else
  localparam int LAT   = 3;
  localparam int NREAL = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lse_clk_in;
  logic       lseon;
  logic       lsebyp;
  logic [1:0] lsedrv;
  logic       lsecsson;
  logic       lserdy;
  logic       lsecss_fail;
  logic       lse_osc_en;
  logic       lse_osc_byp;
  logic [1:0] lse_osc_drv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rcc_lse_ctrl #(
    .STARTUP_EDGES (16),
    .BYP_EDGES     (4),
    .CSS_TIMEOUT   (8),
    .CNT_W         (13),
    .WDT_W         (7)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lse_clk_in  (lse_clk_in),
    .lseon       (lseon),
    .lsebyp      (lsebyp),
    .lsedrv      (lsedrv),
    .lsecsson    (lsecsson),
    .lserdy      (lserdy),
    .lsecss_fail (lsecss_fail),
    .lse_osc_en  (lse_osc_en),
    .lse_osc_byp (lse_osc_byp),
    .lse_osc_drv (lse_osc_drv)
  );

  // Expected word layout: {rdy, fail, en, byp, drv[1:0]}
  typedef struct {
    logic       rst_n;
    logic       lseon;
    logic       lsebyp;
    logic [1:0] drv;
    logic       csson;
    int         ncyc;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [5:0] exp);
    logic [5:0] got;
    got = {lserdy, lsecss_fail, lse_osc_en, lse_osc_byp, lse_osc_drv};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy/fail/en/byp/drv=%b required %b", nm, got, exp);
    end
  endtask

  // One LSE period: 5 clk high, 5 clk low (clk = 10x LSE)
  task automatic lse_period();
    lse_clk_in = 1'b1;
    repeat (5) tick();
    lse_clk_in = 1'b0;
    repeat (5) tick();
  endtask

  // Rising edge that should complete startup; checks exact ready cycle
  task automatic rise_check(input string nm, input logic [5:0] exp_pre,
                            input logic [5:0] exp_post);
    lse_clk_in = 1'b1;
    repeat (LAT - 1) tick();
    check({nm, "_early"}, exp_pre);
    tick();
    check(nm, exp_post);
  endtask

  task automatic finish_high();
    repeat (5 - LAT) tick();
    lse_clk_in = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    lse_clk_in = 1'b0;
    lseon      = 1'b0;
    lsebyp     = 1'b0;
    lsedrv     = 2'd0;
    lsecsson   = 1'b0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0,  2, 6'b000000}; // reset
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0,  1, 6'b000010}; // drv follows in OFF
    tbl[2] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0,  1, 6'b001001}; // crystal enable
    tbl[3] = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b0,  1, 6'b001011}; // lsebyp ignored
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0,  1, 6'b000011}; // disable
    tbl[5] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0,  1, 6'b000100}; // bypass enable
    tbl[6] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 20, 6'b000100}; // no CSS in startup
    tbl[7] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0,  1, 6'b000000}; // back to OFF

    for (int i = 0; i < 8; i++) begin
      rst_n    = tbl[i].rst_n;
      lseon    = tbl[i].lseon;
      lsebyp   = tbl[i].lsebyp;
      lsedrv   = tbl[i].drv;
      lsecsson = tbl[i].csson;
      repeat (tbl[i].ncyc) tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Crystal startup: 16 edges to ready
    lsecsson = 1'b0;
    lsebyp   = 1'b0;
    lsedrv   = 2'd1;
    lseon    = 1'b1;
    tick();
    check("xtal_en", 6'b001001);
    repeat (15) lse_period();
    check("xtal_15", 6'b001001);
    rise_check("xtal_rdy", 6'b001001, 6'b101001);
    finish_high();

    // Bypass startup with lsebyp dropped mid-startup
    lseon = 1'b0;
    tick();
    check("xtal_off", 6'b000001);
    lsebyp = 1'b1;
    lseon  = 1'b1;
    tick();
    check("byp_en", 6'b000101);
    repeat (2) lse_period();
    lsebyp = 1'b0;
    lse_period();
    check("byp_toggle", 6'b000101);
    rise_check("byp_rdy", 6'b000101, 6'b100101);

    // CSS trip: LSE stops low right after ready
    lsecsson   = 1'b1;
    lse_clk_in = 1'b0;
    repeat (7) tick();
    check("css_pre", 6'b100101);
    tick();
    check("css_trip", 6'b010101);
    repeat (2) lse_period();
    check("css_sticky", 6'b010101);
    lseon = 1'b0;
    tick();
    check("css_clear", 6'b000001);

    // Back to ready in bypass mode, CSS off
    lsecsson = 1'b0;
    lsebyp   = 1'b1;
    lseon    = 1'b1;
    tick();
    repeat (3) lse_period();
    rise_check("byp_rdy2", 6'b000101, 6'b100101);
    finish_high();

    // Edge detected exactly on the 8th edge-less cycle: no trip
    lsecsson = 1'b1;
    repeat (8 - LAT) tick();
    lse_clk_in = 1'b1;
    repeat (LAT) tick();
    check("css_edge_at_limit", 6'b100101);

    // CSS disabled with LSE stopped: never trips
    lsecsson   = 1'b0;
    lse_clk_in = 1'b0;
    repeat (100) tick();
    check("css_off_stopped", 6'b100101);

    // Disable in the same cycle as the timeout
    lsecsson = 1'b1;
    repeat (7) tick();
    lseon = 1'b0;
    tick();
    check("off_beats_timeout", 6'b000001);
    lsecsson = 1'b0;

    // Reset during crystal startup at edge 10, then full restart
    lsedrv = 2'd2;
    lsebyp = 1'b0;
    lseon  = 1'b1;
    tick();
    check("rst_seq_en", 6'b001010);
    repeat (9) lse_period();
    lse_clk_in = 1'b1;
    repeat (LAT) tick();
    rst_n      = 1'b0;
    lse_clk_in = 1'b0;
    tick();
    check("rst_mid", 6'b000000);
    rst_n = 1'b1;
    tick();
    check("rst_release", 6'b001010);
    repeat (15) lse_period();
    check("rst_restart_15", 6'b001010);
    rise_check("rst_rdy", 6'b001010, 6'b101010);
    finish_high();

    // Two 1-cycle glitches during bypass startup
    lseon = 1'b0;
    tick();
    lsebyp = 1'b1;
    lseon  = 1'b1;
    tick();
    check("glitch_en", 6'b000110);
    repeat (2) begin
      lse_clk_in = 1'b1;
      tick();
      lse_clk_in = 1'b0;
      repeat (5) tick();
    end
    repeat (NREAL - 1) lse_period();
    check("glitch_pre", 6'b000110);
    rise_check("glitch_rdy", 6'b000110, 6'b100110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
